// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: shadow tag entries,
// forwarding select encoding and the tag match helper.
package hazard_pkg;

    // Tag rd field is sized for the widest supported register index; narrower
    // indices are zero-extended on entry (REG_ADDR_W must not exceed this).
    localparam int TAG_RD_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                reg_write;
        logic                is_load;
    } tag_entry_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_WB    = 2'd3
    } fwd_sel_e;

    function automatic logic tag_match(
        input tag_entry_t          e,
        input logic [TAG_RD_W-1:0] rs,
        input logic                uses,
        input logic                id_valid
    );
        return e.valid & e.reg_write & (e.rd != '0) & (e.rd == rs) & uses & id_valid;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, redirect flush and registered execute-stage forwarding
// selects, driven from a shadow pipeline of in-flight destination tags.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter  int REG_ADDR_W   = 5,
    parameter  int FWD_STAGES   = 3,
    parameter  int LOAD_LATENCY = 1,
    parameter  int CNT_W        = 16,
    localparam int TRACK_DEPTH  = (FWD_STAGES > LOAD_LATENCY + 1) ? FWD_STAGES : LOAD_LATENCY + 1,
    localparam int SEL_W        = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic                  idRegWrite,
    input  logic                  idIsLoad,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flushFetchToDecode,
    output logic                  flushDecodeToExecute,
    output logic [SEL_W-1:0]      fwdSelRs1Ex,
    output logic [SEL_W-1:0]      fwdSelRs2Ex,
    output logic [CNT_W-1:0]      stallCount,
    output logic [CNT_W-1:0]      flushCount
);

    tag_entry_t tag_q [TRACK_DEPTH];
    tag_entry_t tag_d [TRACK_DEPTH];
    tag_entry_t id_tag;

    logic [TAG_RD_W-1:0]    rs1_ext, rs2_ext;
    logic [TRACK_DEPTH-1:0] m1, m2;
    logic                   lu1, lu2, stall_int;
    logic [SEL_W-1:0]       sel1, sel2;
    logic [SEL_W-1:0]       fwd_sel_rs1_q, fwd_sel_rs1_d;
    logic [SEL_W-1:0]       fwd_sel_rs2_q, fwd_sel_rs2_d;

    assign rs1_ext = TAG_RD_W'(idRs1);
    assign rs2_ext = TAG_RD_W'(idRs2);

    for (genvar p = 0; p < TRACK_DEPTH; p++) begin : g_match
        assign m1[p] = tag_match(tag_q[p], rs1_ext, idUsesRs1, idValid);
        assign m2[p] = tag_match(tag_q[p], rs2_ext, idUsesRs2, idValid);
    end

    // Scan oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        lu1  = 1'b0;
        lu2  = 1'b0;
        sel1 = SEL_W'(FWD_RF);
        sel2 = SEL_W'(FWD_RF);
        for (int p = TRACK_DEPTH - 1; p >= 0; p--) begin
            if (m1[p]) begin
                lu1  = tag_q[p].is_load && (p < LOAD_LATENCY);
                sel1 = (p < FWD_STAGES) ? SEL_W'(p + 1) : SEL_W'(FWD_RF);
            end
            if (m2[p]) begin
                lu2  = tag_q[p].is_load && (p < LOAD_LATENCY);
                sel2 = (p < FWD_STAGES) ? SEL_W'(p + 1) : SEL_W'(FWD_RF);
            end
        end
    end

    assign stall_int            = (lu1 || lu2) && !redirect;
    assign stall                = stall_int;
    assign flushFetchToDecode   = redirect;
    assign flushDecodeToExecute = redirect;

    always_comb begin
        id_tag           = '0;
        id_tag.valid     = idValid;
        id_tag.rd        = TAG_RD_W'(idRd);
        id_tag.reg_write = idRegWrite;
        id_tag.is_load   = idIsLoad;

        for (int p = 0; p < TRACK_DEPTH; p++) tag_d[p] = '0;
        tag_d[0] = (stall_int || redirect) ? '0 : id_tag;
        // A redirect kills the instruction currently in execute as it moves on.
        for (int p = 1; p < TRACK_DEPTH; p++) begin
            tag_d[p] = tag_q[p-1];
            if (p == 1 && redirect) tag_d[p].valid = 1'b0;
        end

        fwd_sel_rs1_d = (stall_int || redirect) ? SEL_W'(FWD_RF) : sel1;
        fwd_sel_rs2_d = (stall_int || redirect) ? SEL_W'(FWD_RF) : sel2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < TRACK_DEPTH; p++) tag_q[p] <= '0;
            fwd_sel_rs1_q <= '0;
            fwd_sel_rs2_q <= '0;
        end else begin
            tag_q         <= tag_d;
            fwd_sel_rs1_q <= fwd_sel_rs1_d;
            fwd_sel_rs2_q <= fwd_sel_rs2_d;
        end
    end

    assign fwdSelRs1Ex = fwd_sel_rs1_q;
    assign fwdSelRs2Ex = fwd_sel_rs2_q;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_int),
        .count (stallCount)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (redirect),
        .count (flushCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: default, LOAD_LATENCY=2 and CNT_W=4 instances share one
// stimulus stream; a vector table plus hand sequences for multi-cycle cases.
module tb_pipeline_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       idValid, idUsesRs1, idUsesRs2, idRegWrite, idIsLoad, redirect;
    logic [4:0] idRs1, idRs2, idRd;

    logic        st0, ff0, fd0, st1, ff1, fd1, st2, ff2, fd2;
    logic [1:0]  s1_0, s2_0, s1_1, s2_1, s1_2, s2_2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    always #5 clock = ~clock;

    pipeline_hazard_unit u_dut0 (
        .clock(clock), .reset(reset), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd), .idRegWrite(idRegWrite),
        .idIsLoad(idIsLoad), .redirect(redirect), .stall(st0), .flushFetchToDecode(ff0),
        .flushDecodeToExecute(fd0), .fwdSelRs1Ex(s1_0), .fwdSelRs2Ex(s2_0),
        .stallCount(sc0), .flushCount(fc0));

    pipeline_hazard_unit #(.LOAD_LATENCY(2)) u_dut1 (
        .clock(clock), .reset(reset), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd), .idRegWrite(idRegWrite),
        .idIsLoad(idIsLoad), .redirect(redirect), .stall(st1), .flushFetchToDecode(ff1),
        .flushDecodeToExecute(fd1), .fwdSelRs1Ex(s1_1), .fwdSelRs2Ex(s2_1),
        .stallCount(sc1), .flushCount(fc1));

    pipeline_hazard_unit #(.CNT_W(4)) u_dut2 (
        .clock(clock), .reset(reset), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd), .idRegWrite(idRegWrite),
        .idIsLoad(idIsLoad), .redirect(redirect), .stall(st2), .flushFetchToDecode(ff2),
        .flushDecodeToExecute(fd2), .fwdSelRs1Ex(s1_2), .fwdSelRs2Ex(s2_2),
        .stallCount(sc2), .flushCount(fc2));

    typedef struct {
        logic       v, u1, u2, rw, ld, rdr;
        logic [4:0] rs1, rs2, rd;
        logic       e_st, e_fl;
        logic [1:0] e_s1, e_s2;
    } vec_t;

    vec_t tbl[15];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                                input logic u2, input int rd, input logic rw, input logic ld,
                                input logic rdr, input logic e_st, input logic e_fl,
                                input int e_s1, input int e_s2);
        vec_t t;
        t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = 5'(rd); t.rw = rw; t.ld = ld; t.rdr = rdr;
        t.e_st = e_st; t.e_fl = e_fl; t.e_s1 = 2'(e_s1); t.e_s2 = 2'(e_s2);
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input logic v, input int rs1, input int rs2, input logic u1,
                       input logic u2, input int rd, input logic rw, input logic ld,
                       input logic rdr);
        idValid = v; idRs1 = 5'(rs1); idRs2 = 5'(rs2); idUsesRs1 = u1; idUsesRs2 = u2;
        idRd = 5'(rd); idRegWrite = rw; idIsLoad = ld; redirect = rdr;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset stall", st0, 0);
        chk("reset flush", ff0 | fd0, 0);
        chk("reset sel", {s1_0, s2_0}, 0);
        chk("reset counts", {sc0, fc0}, 0);
        chk("reset counts cnt4", {sc2, fc2}, 0);

        // v rs1 rs2 u1 u2 rd rw ld redir | stall flush sel1 sel2
        tbl[0]  = mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1,  3,  0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1,  5,  1, 1, 1,  6, 1, 0, 0, 0, 0, 2, 0);
        tbl[3]  = mk(1,  6,  5, 1, 1, 11, 1, 0, 0, 0, 0, 1, 3);
        tbl[4]  = mk(1,  5, 10, 1, 1, 12, 1, 0, 0, 0, 0, 0, 3);
        tbl[5]  = mk(1,  1,  0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1,  0,  0, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1,  1,  0, 1, 0,  9, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1,  2,  0, 1, 0,  9, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1,  9,  9, 1, 1, 14, 1, 0, 0, 0, 0, 1, 1);
        tbl[10] = mk(1, 14, 14, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 15,  0, 1, 0, 15, 1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 15,  0, 1, 0, 16, 0, 0, 0, 0, 0, 2, 0);
        tbl[13] = mk(1, 16,  0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1,  1,  2, 1, 1, 17, 1, 0, 1, 0, 1, 0, 0);

        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drv(tbl[i].v, int'(tbl[i].rs1), int'(tbl[i].rs2), tbl[i].u1, tbl[i].u2,
                int'(tbl[i].rd), tbl[i].rw, tbl[i].ld, tbl[i].rdr);
            #1;
            chk($sformatf("vec%0d stall", i), st0, tbl[i].e_st);
            chk($sformatf("vec%0d flush", i), ff0 & fd0, tbl[i].e_fl);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d sel1", i), s1_0, tbl[i].e_s1);
            chk($sformatf("vec%0d sel2", i), s2_0, tbl[i].e_s2);
        end
        chk("table stallCount", sc0, 0);
        chk("table flushCount", fc0, 1);

        // Load-use with LOAD_LATENCY 1 (dut0) and 2 (dut1).
        do_reset();
        @(negedge clock); drv(1, 1, 0, 1, 0, 7, 1, 1, 0);
        #1 chk("lu lw no stall", st0, 0);
        @(negedge clock); drv(1, 7, 7, 1, 1, 8, 1, 0, 0);
        #1 chk("lu c1 stall ll1", st0, 1);
        chk("lu c1 stall ll2", st1, 1);
        @(posedge clock); #1 chk("lu c1 stallCount", sc0, 1);
        chk("lu c1 sel bubble", {s1_0, s2_0}, 0);
        @(negedge clock);
        #1 chk("lu c2 stall ll1", st0, 0);
        chk("lu c2 stall ll2", st1, 1);
        @(posedge clock); #1;
        chk("lu ll1 sel1", s1_0, 2);
        chk("lu ll1 sel2", s2_0, 2);
        chk("lu ll2 sel1 held", s1_1, 0);
        chk("lu ll1 stallCount", sc0, 1);
        chk("lu ll2 stallCount mid", sc1, 2);
        @(negedge clock);
        #1 chk("lu c3 stall ll2", st1, 0);
        @(posedge clock); #1;
        chk("lu ll2 sel1", s1_1, 3);
        chk("lu ll2 sel2", s2_1, 3);
        chk("lu ll2 stallCount", sc1, 2);

        // Redirect during a load-use hazard.
        do_reset();
        @(negedge clock); drv(1, 1, 0, 1, 0, 7, 1, 1, 0);
        @(negedge clock); drv(1, 7, 7, 1, 1, 8, 1, 0, 1);
        #1 chk("rd stall ll1", st0, 0);
        chk("rd stall ll2", st1, 0);
        chk("rd flushes", {ff0, fd0}, 3);
        @(posedge clock); #1;
        chk("rd sel", {s1_0, s2_0}, 0);
        chk("rd flushCount", fc0, 1);
        chk("rd stallCount", sc0, 0);
        @(negedge clock); drv(1, 7, 8, 1, 1, 9, 1, 0, 0);
        #1 chk("rd killed stall ll1", st0, 0);
        chk("rd killed stall ll2", st1, 0);
        chk("rd killed flush", ff0, 0);
        @(posedge clock); #1;
        chk("rd killed sel1", s1_0, 0);
        chk("rd killed sel2", s2_0, 0);
        chk("rd killed sel ll2", {s1_1, s2_1}, 0);

        // Repeated load-use hazards drive counters into saturation.
        do_reset();
        @(negedge clock); drv(1, 7, 0, 1, 0, 7, 1, 1, 0);
        for (int i = 0; i < 50; i++) @(posedge clock);
        #1;
        chk("sat stallCount ll1", sc0, 25);
        chk("sat stallCount ll2", sc1, 33);
        chk("sat stallCount cnt4", sc2, 15);
        @(negedge clock); redirect = 1'b1;
        for (int i = 0; i < 20; i++) @(posedge clock);
        #1;
        chk("sat flushCount", fc0, 20);
        chk("sat flushCount cnt4", fc2, 15);
        chk("sat stallCount frozen", sc0, 25);

        // Asynchronous reset in the middle of a multi-cycle stall.
        do_reset();
        @(negedge clock); drv(1, 1, 0, 1, 0, 7, 1, 1, 0);
        @(negedge clock); drv(1, 7, 7, 1, 1, 8, 1, 0, 0);
        #1 chk("ar stall pre", st1, 1);
        @(posedge clock); #1 chk("ar stallCount pre", sc1, 1);
        @(negedge clock);
        #1 chk("ar stall held", st1, 1);
        #1 reset = 1'b1;
        #1;
        chk("ar stall async", st1, 0);
        chk("ar stallCount async", sc1, 0);
        chk("ar stallCount ll1 async", sc0, 0);
        chk("ar sel async", {s1_1, s2_1, s1_0, s2_0}, 0);
        @(negedge clock); reset = 1'b0;
        #1 chk("ar post stall ll1", st0, 0);
        chk("ar post stall ll2", st1, 0);
        @(posedge clock); #1;
        chk("ar post sel", {s1_0, s2_0, s1_1, s2_1}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
